// File: rtl/iobus_ctrl_if.sv
// iobus_ctrl_if: CPU data-port bundle between the AVR core and iobus_ctrl.
//   address  CPU data address (16)
//   wren     CPU write strobe
//   data_o   CPU write data (8)
//   data_i   read data returned to the CPU (8)
// The master modport is the CPU side and the slave modport is the controller side.
interface iobus_ctrl_if;
  logic [15:0] address;
  logic        wren;
  logic [7:0]  data_o;
  logic [7:0]  data_i;

  modport master (output address, output wren, output data_o, input data_i);
  modport slave  (input address, input wren, input data_o, output data_i);
endinterface

// File: rtl/iobus_ctrl.sv
// iobus_ctrl: memory-window and I/O-port controller for the AVR core.
// The module decodes the CPU bus into SRAM, the banked TEXT/GRPH window and a
// 32-byte port block. It also holds the keyboard scancode FIFO and the SDRAM
// request/acknowledge engine. All state changes on the falling edge of clock.
// Ports:
//   clock, reset_n                          clock (falling edge), async active-low reset
//   bus                                     CPU address/wren/data_o/data_i (slave side)
//   data_o_sram/text/grph, data_w_*         memory read data and write enables
//   bank, cursor_x, cursor_y, videomode     video/bank registers
//   ps2_data, ps2_hit, kb_ascii, kb_shift   keyboard input and converter link
//   sdram_*                                 SDRAM address, data, direction and handshake
//   sd_cmd, sd_out, sd_signal, sd_din,
//   sd_busy, sd_timeout                     SD-SPI command/data/status
module iobus_ctrl #(
  parameter logic [15:0] WIN_BASE    = 16'hF000,
  parameter logic [15:0] PORT_BASE   = 16'h0020,
  parameter logic [7:0]  TEXT_LO     = 8'h02,
  parameter logic [7:0]  TEXT_HI     = 8'h03,
  parameter logic [7:0]  GRPH_LO     = 8'h20,
  parameter logic [7:0]  GRPH_HI     = 8'h3F,
  parameter int          KFIFO_DEPTH = 16,
  parameter int          SDRAM_AW    = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  iobus_ctrl_if.slave         bus,
  input  logic [7:0]          data_o_sram,
  input  logic [7:0]          data_o_text,
  input  logic [7:0]          data_o_grph,
  output logic                data_w_sram,
  output logic                data_w_text,
  output logic                data_w_grph,
  output logic [7:0]          bank,
  output logic [7:0]          cursor_x,
  output logic [7:0]          cursor_y,
  output logic [7:0]          videomode,
  input  logic [7:0]          ps2_data,
  input  logic                ps2_hit,
  input  logic [6:0]          kb_ascii,
  output logic                kb_shift,
  output logic [SDRAM_AW-1:0] sdram_address,
  output logic [7:0]          sdram_i_data,
  input  logic [7:0]          sdram_o_data,
  output logic                sdram_we,
  output logic                sdram_req,
  input  logic                sdram_ack,
  output logic [1:0]          sd_cmd,
  output logic [7:0]          sd_out,
  output logic                sd_signal,
  input  logic [7:0]          sd_din,
  input  logic                sd_busy,
  input  logic                sd_timeout
);
  localparam int PW = $clog2(KFIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, REQ} sd_state_t;
  sd_state_t state_q, state_d;

  logic [7:0]    kfifo [KFIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] kcount;
  logic          kovf, up, autoinc;
  logic [7:0]    sdram_rdata;

  // Address decode: the window wins over the port block.
  logic        in_win, in_port, port_wr;
  logic [15:0] port_off;
  logic [4:0]  port;
  logic        text_bank, grph_bank;

  assign in_win    = (bus.address >= WIN_BASE);
  assign port_off  = bus.address - PORT_BASE;
  assign in_port   = !in_win && (bus.address >= PORT_BASE) && (port_off < 16'd32);
  assign port      = port_off[4:0];
  assign port_wr   = in_port && bus.wren;
  assign text_bank = (bank >= TEXT_LO) && (bank <= TEXT_HI);
  assign grph_bank = (bank >= GRPH_LO) && (bank <= GRPH_HI);

  logic kfull, knonempty, push_req, push, pop, busy, sd_start, sd_done, addr_wr;
  assign kfull     = (kcount == CW'(KFIFO_DEPTH));
  assign knonempty = (kcount != '0);
  assign push_req  = ps2_hit && (ps2_data != 8'hF0);
  assign pop       = port_wr && (port == 5'h02) && bus.data_o[0] && knonempty;
  // A pop on the same edge frees a slot, so a push into a full FIFO still fits.
  assign push      = push_req && (!kfull || pop);
  assign busy      = (state_q == REQ);
  assign sdram_req = busy;
  assign sd_start  = port_wr && (port == 5'h14) && !busy;
  assign sd_done   = busy && sdram_ack;
  assign addr_wr   = port_wr && (port[4:2] == 3'b100) && !busy;

  // The SDRAM address is handled as a zero-extended 32-bit value so that byte
  // lanes above SDRAM_AW read as zero and are dropped on write.
  logic [31:0] addr_ext, addr_wr_val;
  logic [8:0]  kcount_ext;
  assign addr_ext   = 32'(sdram_address);
  assign kcount_ext = 9'(kcount);

  always_comb begin
    addr_wr_val = addr_ext;
    addr_wr_val[{port[1:0], 3'b000} +: 8] = bus.data_o;
  end

  // Read mux and memory write enables; port reads override SRAM data.
  always_comb begin
    bus.data_i  = data_o_sram;
    data_w_sram = 1'b0;
    data_w_text = 1'b0;
    data_w_grph = 1'b0;
    if (in_win) begin
      if (text_bank) begin
        data_w_text = bus.wren;
        bus.data_i  = data_o_text;
      end else if (grph_bank) begin
        data_w_grph = bus.wren;
        bus.data_i  = data_o_grph;
      end else begin
        bus.data_i  = 8'hFF;
      end
    end else begin
      data_w_sram = bus.wren;
      if (in_port) begin
        case (port)
          5'h00: bus.data_i = bank;
          5'h01: bus.data_i = knonempty ? kfifo[rd_ptr] : 8'h00;
          5'h02: bus.data_i = {sdram_we, busy, sd_busy, sd_timeout, 1'b0, kfull, kovf, knonempty};
          5'h03: bus.data_i = kcount_ext[8] ? 8'hFF : kcount_ext[7:0];
          5'h0C: bus.data_i = cursor_x;
          5'h0D: bus.data_i = cursor_y;
          5'h10, 5'h11, 5'h12, 5'h13: bus.data_i = addr_ext[{port[1:0], 3'b000} +: 8];
          5'h14: bus.data_i = sdram_rdata;
          5'h15: bus.data_i = {7'b0, autoinc};
          5'h18: bus.data_i = videomode;
          5'h19: bus.data_i = sd_din;
          5'h1A: bus.data_i = {sd_signal, 5'b0, sd_cmd};
          default: bus.data_i = data_o_sram;
        endcase
      end
    end
  end

  // SDRAM next-state: a data write starts an access, an ack finishes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (sd_start)  state_d = REQ;
      REQ:  if (sdram_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage has no reset; occupancy gates every read of it.
  always_ff @(negedge clock) begin
    if (push) kfifo[wr_ptr] <= {up, kb_ascii};
  end

  // Registers, FIFO control and SDRAM state.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      bank          <= '0;
      cursor_x      <= '0;
      cursor_y      <= '0;
      videomode     <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      kcount        <= '0;
      kovf          <= 1'b0;
      up            <= 1'b0;
      kb_shift      <= 1'b0;
      sdram_address <= '0;
      sdram_i_data  <= '0;
      sdram_we      <= 1'b0;
      sdram_rdata   <= '0;
      autoinc       <= 1'b0;
      sd_cmd        <= '0;
      sd_out        <= '0;
      sd_signal     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (port_wr) begin
        case (port)
          5'h00: bank      <= bus.data_o;
          5'h0C: cursor_x  <= bus.data_o;
          5'h0D: cursor_y  <= bus.data_o;
          5'h15: autoinc   <= bus.data_o[0];
          5'h18: videomode <= bus.data_o;
          5'h19: sd_out    <= bus.data_o;
          5'h1A: begin
            sd_signal <= bus.data_o[7];
            sd_cmd    <= bus.data_o[1:0];
          end
          default: ;
        endcase
        if (port == 5'h02) begin
          if (!busy) sdram_we <= bus.data_o[7];
          if (bus.data_o[1]) kovf <= 1'b0;
        end
      end
      if (sd_start) sdram_i_data <= bus.data_o;
      if (addr_wr) sdram_address <= addr_wr_val[SDRAM_AW-1:0];
      if (sd_done) begin
        if (!sdram_we) sdram_rdata <= sdram_o_data;
        if (autoinc) sdram_address <= sdram_address + SDRAM_AW'(1);
      end
      // A dropped code sets overflow; this takes priority over a same-edge clear.
      if (push_req && !push) kovf <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      kcount <= kcount + CW'(1);
      else if (pop && !push) kcount <= kcount - CW'(1);
      if (ps2_hit) begin
        if ((ps2_data == 8'h12) || (ps2_data == 8'h59)) kb_shift <= ~up;
        up <= (ps2_data == 8'hF0);
      end
    end
  end
endmodule

// File: tb/tb_iobus_ctrl.sv
// tb_iobus_ctrl: self-checking bench for iobus_ctrl.
// Decode behaviour is driven from a vector table; the keyboard FIFO and SDRAM
// read data are checked through scoreboard queues filled as stimulus is driven.
module tb_iobus_ctrl;
  localparam logic [15:0] PB = 16'h0020;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  data_o_sram, data_o_text, data_o_grph;
  logic        data_w_sram, data_w_text, data_w_grph;
  logic [7:0]  bank, cursor_x, cursor_y, videomode;
  logic [7:0]  ps2_data;
  logic        ps2_hit;
  logic [6:0]  kb_ascii;
  logic        kb_shift;
  logic [31:0] sdram_address;
  logic [7:0]  sdram_i_data, sdram_o_data;
  logic        sdram_we, sdram_req, sdram_ack;
  logic [1:0]  sd_cmd;
  logic [7:0]  sd_out, sd_din;
  logic        sd_signal, sd_busy, sd_timeout;

  iobus_ctrl_if bus();

  always #5 clock = ~clock;

  iobus_ctrl dut (
    .clock(clock), .reset_n(reset_n), .bus(bus),
    .data_o_sram(data_o_sram), .data_o_text(data_o_text), .data_o_grph(data_o_grph),
    .data_w_sram(data_w_sram), .data_w_text(data_w_text), .data_w_grph(data_w_grph),
    .bank(bank), .cursor_x(cursor_x), .cursor_y(cursor_y), .videomode(videomode),
    .ps2_data(ps2_data), .ps2_hit(ps2_hit), .kb_ascii(kb_ascii), .kb_shift(kb_shift),
    .sdram_address(sdram_address), .sdram_i_data(sdram_i_data), .sdram_o_data(sdram_o_data),
    .sdram_we(sdram_we), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .sd_cmd(sd_cmd), .sd_out(sd_out), .sd_signal(sd_signal),
    .sd_din(sd_din), .sd_busy(sd_busy), .sd_timeout(sd_timeout)
  );

  typedef struct {
    logic [7:0]  bank;
    logic [15:0] addr;
    logic        wren;
    logic [7:0]  exp_rd;
    logic        exp_sram;
    logic        exp_text;
    logic        exp_grph;
  } vec_t;

  vec_t vecs[9];

  int checks = 0;
  int errors = 0;
  logic [7:0] kb_q[$];
  logic [7:0] sd_q[$];
  logic       model_up = 1'b0;
  logic       model_shift = 1'b0;
  int         model_count = 0;
  logic [7:0] rd;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic write_port(input logic [15:0] a, input logic [7:0] d);
    bus.address = a;
    bus.data_o  = d;
    bus.wren    = 1'b1;
    @(negedge clock);
    #1;
    bus.wren    = 1'b0;
  endtask

  task automatic read_port(input logic [15:0] a, output logic [7:0] d);
    bus.address = a;
    bus.wren    = 1'b0;
    #1;
    d = bus.data_i;
  endtask

  task automatic apply_stimulus(input vec_t v);
    write_port(PB, v.bank);
    bus.address = v.addr;
    bus.data_o  = 8'h5A;
    bus.wren    = v.wren;
    #1;
  endtask

  // Drive one scancode and update the keyboard model.
  task automatic kb_hit(input logic [7:0] code, input logic [6:0] ascii);
    ps2_data = code;
    kb_ascii = ascii;
    ps2_hit  = 1'b1;
    if (code == 8'hF0) begin
      model_up = 1'b1;
    end else begin
      if (model_count < 16) begin
        kb_q.push_back({model_up, ascii});
        model_count++;
      end
      if (code == 8'h12 || code == 8'h59) model_shift = ~model_up;
      model_up = 1'b0;
    end
    @(negedge clock);
    #1;
    ps2_hit = 1'b0;
  endtask

  task automatic drain_fifo();
    while (kb_q.size() > 0) begin
      read_port(PB + 16'h01, rd);
      check_output("keyb_head", {24'h0, rd}, {24'h0, kb_q[0]});
      void'(kb_q.pop_front());
      write_port(PB + 16'h02, 8'h01);
      model_count--;
    end
    read_port(PB + 16'h03, rd);
    check_output("kcount_empty", {24'h0, rd}, 32'h0);
    read_port(PB + 16'h01, rd);
    check_output("keyb_empty", {24'h0, rd}, 32'h0);
  endtask

  task automatic ack_pulse(input logic [7:0] odata);
    sdram_o_data = odata;
    sdram_ack    = 1'b1;
    @(negedge clock);
    #1;
    sdram_ack    = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h02, 16'hF010, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h03, 16'hFFFF, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'h05, 16'hF000, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h20, 16'hF123, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h3F, 16'hFFFE, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h40, 16'hF000, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h01, 16'hEFFF, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h02, 16'h0100, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{8'h02, 16'h0000, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0};

    bus.address  = 16'h0100;
    bus.wren     = 1'b0;
    bus.data_o   = 8'h00;
    data_o_sram  = 8'h11;
    data_o_text  = 8'h22;
    data_o_grph  = 8'h33;
    ps2_data     = 8'h00;
    ps2_hit      = 1'b0;
    kb_ascii     = 7'h00;
    sdram_o_data = 8'h00;
    sdram_ack    = 1'b0;
    sd_din       = 8'h5E;
    sd_busy      = 1'b0;
    sd_timeout   = 1'b0;

    repeat (2) @(negedge clock);
    @(posedge clock);
    reset_n = 1'b1;
    #1;

    // Reset state
    check_output("rst_bank", {24'h0, bank}, 32'h0);
    check_output("rst_req", {31'h0, sdram_req}, 32'h0);
    check_output("rst_addr", sdram_address, 32'h0);
    read_port(PB + 16'h02, rd);
    check_output("rst_status", {24'h0, rd}, 32'h0);
    read_port(PB + 16'h03, rd);
    check_output("rst_kcount", {24'h0, rd}, 32'h0);

    // Window and SRAM decode
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d_bank", i), {24'h0, bank}, {24'h0, vecs[i].bank});
      check_output($sformatf("vec%0d_rd", i), {24'h0, bus.data_i}, {24'h0, vecs[i].exp_rd});
      check_output($sformatf("vec%0d_we", i), {29'h0, data_w_sram, data_w_text, data_w_grph},
                   {29'h0, vecs[i].exp_sram, vecs[i].exp_text, vecs[i].exp_grph});
      bus.wren = 1'b0;
    end

    // Plain registers and SD-SPI ports
    write_port(PB + 16'h0C, 8'hAA);
    write_port(PB + 16'h0D, 8'hBB);
    write_port(PB + 16'h18, 8'hCC);
    write_port(PB + 16'h19, 8'hDD);
    write_port(PB + 16'h1A, 8'h83);
    check_output("cursor_xy", {16'h0, cursor_x, cursor_y}, 32'hAABB);
    check_output("videomode", {24'h0, videomode}, 32'hCC);
    check_output("sd_out", {24'h0, sd_out}, 32'hDD);
    check_output("sd_cmd_sig", {29'h0, sd_signal, sd_cmd}, 32'h7);
    read_port(PB + 16'h1A, rd);
    check_output("sdcmd_rd", {24'h0, rd}, 32'h83);
    read_port(PB + 16'h19, rd);
    check_output("sddat_rd", {24'h0, rd}, 32'h5E);
    read_port(PB + 16'h0D, rd);
    check_output("cursy_rd", {24'h0, rd}, 32'hBB);

    // Keyboard: break prefix and shift tracking
    kb_hit(8'h1C, 7'h61);
    kb_hit(8'hF0, 7'h00);
    kb_hit(8'h1C, 7'h61);
    read_port(PB + 16'h03, rd);
    check_output("kcount_two", {24'h0, rd}, 32'h2);
    drain_fifo();
    kb_hit(8'h12, 7'h10);
    check_output("kb_shift_on", {31'h0, kb_shift}, {31'h0, model_shift});
    kb_hit(8'h1C, model_shift ? 7'h41 : 7'h61);
    kb_hit(8'hF0, 7'h00);
    kb_hit(8'h12, 7'h10);
    check_output("kb_shift_off", {31'h0, kb_shift}, {31'h0, model_shift});
    drain_fifo();

    // Overflow: one push more than the depth
    for (int i = 0; i < 17; i++) kb_hit(8'h20 + 8'(i), 7'(i + 1));
    read_port(PB + 16'h03, rd);
    check_output("kcount_full", {24'h0, rd}, 32'd16);
    read_port(PB + 16'h02, rd);
    check_output("status_ovf", {24'h0, rd}, 32'h07);
    write_port(PB + 16'h02, 8'h02);
    read_port(PB + 16'h02, rd);
    check_output("status_ovf_clr", {24'h0, rd}, 32'h05);

    // Push and pop on the same edge while full
    bus.address = PB + 16'h02;
    bus.data_o  = 8'h01;
    bus.wren    = 1'b1;
    ps2_data    = 8'h45;
    kb_ascii    = 7'h15;
    ps2_hit     = 1'b1;
    void'(kb_q.pop_front());
    kb_q.push_back({model_up, 7'h15});
    @(negedge clock);
    #1;
    bus.wren = 1'b0;
    ps2_hit  = 1'b0;
    read_port(PB + 16'h03, rd);
    check_output("kcount_pushpop", {24'h0, rd}, 32'd16);
    read_port(PB + 16'h02, rd);
    check_output("status_pushpop", {24'h0, rd}, 32'h05);
    drain_fifo();

    // SDRAM write with autoincrement
    write_port(PB + 16'h10, 8'h00);
    write_port(PB + 16'h11, 8'h01);
    write_port(PB + 16'h12, 8'h00);
    write_port(PB + 16'h13, 8'h00);
    write_port(PB + 16'h15, 8'h01);
    write_port(PB + 16'h02, 8'h80);
    write_port(PB + 16'h14, 8'h77);
    check_output("wr_req", {31'h0, sdram_req}, 32'h1);
    check_output("wr_idata", {24'h0, sdram_i_data}, 32'h77);
    read_port(PB + 16'h02, rd);
    check_output("wr_status_busy", {24'h0, rd}, 32'hC0);
    repeat (2) @(negedge clock);
    #1;
    check_output("wr_req_hold", {31'h0, sdram_req}, 32'h1);
    ack_pulse(8'hEE);
    check_output("wr_req_done", {31'h0, sdram_req}, 32'h0);
    check_output("wr_addr_inc", sdram_address, 32'h00000101);
    read_port(PB + 16'h02, rd);
    check_output("wr_status_idle", {24'h0, rd}, 32'h80);
    read_port(PB + 16'h15, rd);
    check_output("sdctl_rd", {24'h0, rd}, 32'h01);

    // SDRAM read with wrap and writes ignored while busy
    write_port(PB + 16'h02, 8'h00);
    for (int i = 0; i < 4; i++) write_port(PB + 16'h10 + 16'(i), 8'hFF);
    write_port(PB + 16'h14, 8'h55);
    check_output("rd_req", {31'h0, sdram_req}, 32'h1);
    write_port(PB + 16'h14, 8'h99);
    write_port(PB + 16'h10, 8'h12);
    write_port(PB + 16'h02, 8'h80);
    check_output("rd_idata_kept", {24'h0, sdram_i_data}, 32'h55);
    check_output("rd_addr_kept", sdram_address, 32'hFFFFFFFF);
    check_output("rd_we_kept", {31'h0, sdram_we}, 32'h0);
    sd_q.push_back(8'hC3);
    ack_pulse(8'hC3);
    read_port(PB + 16'h14, rd);
    check_output("rd_data", {24'h0, rd}, {24'h0, sd_q[0]});
    void'(sd_q.pop_front());
    check_output("rd_addr_wrap", sdram_address, 32'h0);
    read_port(PB + 16'h13, rd);
    check_output("rd_addr_b3", {24'h0, rd}, 32'h0);

    // Reset during an access
    kb_hit(8'h1C, 7'h61);
    write_port(PB + 16'h14, 8'hAA);
    check_output("mid_req", {31'h0, sdram_req}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("mid_rst_req", {31'h0, sdram_req}, 32'h0);
    check_output("mid_rst_regs", {bank, cursor_x, cursor_y, videomode}, 32'h0);
    check_output("mid_rst_sd", {sdram_i_data, 5'h0, sd_signal, sd_cmd, sd_out}, 32'h0);
    check_output("mid_rst_addr", sdram_address, 32'h0);
    read_port(PB + 16'h03, rd);
    check_output("mid_rst_kcount", {24'h0, rd}, 32'h0);
    kb_q.delete();
    model_count = 0;
    model_up    = 1'b0;
    model_shift = 1'b0;
    @(posedge clock);
    reset_n = 1'b1;
    ack_pulse(8'h3C);
    read_port(PB + 16'h14, rd);
    check_output("post_rst_rdata", {24'h0, rd}, 32'h0);
    read_port(PB + 16'h02, rd);
    check_output("post_rst_status", {24'h0, rd}, 32'h0);
    check_output("post_rst_shift", {31'h0, kb_shift}, {31'h0, model_shift});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
